// File: rtl/rgmii_ddr_tx_fmt.sv
// rgmii_ddr_tx_fmt: splits GMII bytes into RGMII DDR nibble/ctl/clock patterns for ODDR cells.
// All pattern outputs are registered from next-state count so data, ctl and forwarded clock align.
module rgmii_ddr_tx_fmt (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] in_data,
    input  logic       in_en,
    input  logic       in_er,
    output logic       in_ready,
    output logic [3:0] out_d_q1,
    output logic [3:0] out_d_q2,
    output logic       out_ctl_q1,
    output logic       out_ctl_q2,
    output logic       out_clk_q1,
    output logic       out_clk_q2
);
    logic [6:0] cnt_q, cnt_d;
    logic [1:0] spd_q, spd_d;
    logic [3:0] hi_q, hi_d, d1_d, d2_d;
    logic       ctl1_d, ctl2_d, hi_load;
    logic [1:0] clk_d;

    function automatic logic [6:0] last_cnt(input logic [1:0] s);
        return s[1] ? 7'd0 : s[0] ? 7'd9 : 7'd99;
    endfunction

    // speed[1] set means gigabit (2'b10 and 2'b11); otherwise 100 when speed[0], else 10
    function automatic logic [1:0] clk_pat(input logic [1:0] s, input logic [6:0] c);
        logic [6:0] h5, h50;
        h5  = (c >= 7'd5) ? c - 7'd5 : c;
        h50 = (c >= 7'd50) ? c - 7'd50 : c;
        return s[1] ? 2'b10 :
               s[0] ? ((h5 < 7'd2) ? 2'b11 : (h5 == 7'd2) ? 2'b10 : 2'b00) :
                      ((h50 < 7'd25) ? 2'b11 : 2'b00);
    endfunction

    assign in_ready = (cnt_q == last_cnt(spd_q)) && !rst;

    always_comb begin
        spd_d   = in_ready ? speed : spd_q;
        cnt_d   = in_ready ? 7'd0 : cnt_q + 7'd1;
        hi_d    = in_ready ? in_data[7:4] : hi_q;
        hi_load = !in_ready && !spd_q[1] && (cnt_d == (spd_q[0] ? 7'd5 : 7'd50));
        d1_d    = in_ready ? in_data[3:0] : hi_load ? hi_q : out_d_q1;
        d2_d    = in_ready ? (speed[1] ? in_data[7:4] : in_data[3:0]) : hi_load ? hi_q : out_d_q2;
        ctl1_d  = in_ready ? in_en : out_ctl_q1;
        ctl2_d  = in_ready ? in_en ^ in_er : out_ctl_q2;
        clk_d   = clk_pat(spd_d, cnt_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= last_cnt(speed);
            spd_q      <= speed;
            hi_q       <= 4'd0;
            out_d_q1   <= 4'd0;
            out_d_q2   <= 4'd0;
            out_ctl_q1 <= 1'b0;
            out_ctl_q2 <= 1'b0;
            out_clk_q1 <= 1'b0;
            out_clk_q2 <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            spd_q      <= spd_d;
            hi_q       <= hi_d;
            out_d_q1   <= d1_d;
            out_d_q2   <= d2_d;
            out_ctl_q1 <= ctl1_d;
            out_ctl_q2 <= ctl2_d;
            out_clk_q1 <= clk_d[1];
            out_clk_q2 <= clk_d[0];
        end
    end
endmodule

// File: tb/tb_rgmii_ddr_tx_fmt.sv
// tb_rgmii_ddr_tx_fmt: table-driven bench with an expected-output queue for the RGMII TX formatter.
module tb_rgmii_ddr_tx_fmt;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] speed;
    logic [7:0] in_data;
    logic       in_en, in_er;
    logic       in_ready;
    logic [3:0] out_d_q1, out_d_q2;
    logic       out_ctl_q1, out_ctl_q2, out_clk_q1, out_clk_q2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] spd;
        logic [7:0] d;
        logic       en, er;
        logic [3:0] a1, a2, b;
        logic       c1, c2;
        int         per;
    } vec_t;

    logic [12:0] sb[$];
    vec_t        tbl[8];

    rgmii_ddr_tx_fmt dut (
        .clk(clk), .rst(rst), .speed(speed), .in_data(in_data), .in_en(in_en), .in_er(in_er),
        .in_ready(in_ready), .out_d_q1(out_d_q1), .out_d_q2(out_d_q2),
        .out_ctl_q1(out_ctl_q1), .out_ctl_q2(out_ctl_q2),
        .out_clk_q1(out_clk_q1), .out_clk_q2(out_clk_q2)
    );

    always #5 clk = ~clk;

    // packed as {ready, clk_q1, clk_q2, ctl_q1, ctl_q2, d_q1, d_q2}
    function automatic logic [12:0] model(input vec_t v, input int k);
        logic [1:0] ck;
        logic [3:0] x1, x2;
        ck = (v.per == 1) ? 2'b10 :
             (v.per == 10) ? (((k % 5) < 2) ? 2'b11 : ((k % 5) == 2) ? 2'b10 : 2'b00) :
             (((k % 50) < 25) ? 2'b11 : 2'b00);
        x1 = (v.per == 1 || k < v.per / 2) ? v.a1 : v.b;
        x2 = (v.per == 1 || k < v.per / 2) ? v.a2 : v.b;
        return {k == v.per - 1, ck, v.c1, v.c2, x1, x2};
    endfunction

    task automatic check(input string nm, input int k);
        logic [12:0] e, a;
        e = sb.pop_front();
        a = {in_ready, out_clk_q1, out_clk_q2, out_ctl_q1, out_ctl_q2, out_d_q1, out_d_q2};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got rdy/clk/ctl/d=%b_%b_%b_%h_%h want %b_%b_%b_%h_%h",
                     nm, k, a[12], a[11:10], a[9:8], a[7:4], a[3:0],
                     e[12], e[11:10], e[9:8], e[7:4], e[3:0]);
        end
    endtask

    task automatic send_byte(input vec_t v, input int ncyc, input string nm);
        speed = v.spd; in_data = v.d; in_en = v.en; in_er = v.er;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s accept ready: got %b want 1", nm, in_ready);
        end
        for (int k = 0; k < ncyc; k++) sb.push_back(model(v, k));
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                speed = ~v.spd; in_data = 8'($urandom); in_en = ~v.en; in_er = ~v.er;
            end
            check(nm, k);
        end
    endtask

    initial begin
        vec_t vr, vp;
        tbl[0] = '{2'b10, 8'h5A, 1'b1, 1'b0, 4'hA, 4'h5, 4'h0, 1'b1, 1'b1, 1};
        tbl[1] = '{2'b10, 8'hC3, 1'b1, 1'b0, 4'h3, 4'hC, 4'h0, 1'b1, 1'b1, 1};
        tbl[2] = '{2'b01, 8'h7E, 1'b1, 1'b1, 4'hE, 4'hE, 4'h7, 1'b1, 1'b0, 10};
        tbl[3] = '{2'b00, 8'h21, 1'b1, 1'b0, 4'h1, 4'h1, 4'h2, 1'b1, 1'b1, 100};
        tbl[4] = '{2'b11, 8'h96, 1'b0, 1'b1, 4'h6, 4'h9, 4'h0, 1'b0, 1'b1, 1};
        tbl[5] = '{2'b01, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 10};
        tbl[6] = '{2'b10, 8'hA5, 1'b1, 1'b1, 4'h5, 4'hA, 4'h0, 1'b1, 1'b0, 1};
        tbl[7] = '{2'b00, 8'h3C, 1'b0, 1'b0, 4'hC, 4'hC, 4'h3, 1'b0, 1'b0, 100};
        rst = 1'b1; speed = 2'b10; in_data = 8'h00; in_en = 1'b0; in_er = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(13'd0);
        check("reset", 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(tbl[i], tbl[i].per, $sformatf("vec%0d", i));
        vp = '{2'b01, 8'h4B, 1'b1, 1'b0, 4'hB, 4'hB, 4'h4, 1'b1, 1'b1, 10};
        send_byte(vp, 7, "pre_reset");
        rst = 1'b1; speed = 2'b01;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_ready: got %b want 0", in_ready);
        end
        sb.push_back(13'd0);
        @(posedge clk); #1;
        check("mid_reset", 0);
        rst = 1'b0;
        vr = '{2'b01, 8'hD2, 1'b1, 1'b0, 4'h2, 4'h2, 4'hD, 1'b1, 1'b1, 10};
        send_byte(vr, 10, "post_reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rgmii_ddr_tx_fmt.md
# rgmii_ddr_tx_fmt

Transmit-side formatter for a source-synchronous DDR (RGMII) interface. It sits between the MAC's byte-wide GMII-style transmit stream and the output DDR registers. It accepts one byte per byte period through a ready strobe, splits the byte into nibbles according to link speed (1000/100/10), and produces registered rising/falling-edge data, control and forwarded-clock patterns. Those patterns drive ODDR cells directly.

## Interface
No parameters: the data path is fixed at 8-bit in, 4-bit DDR out, and timing assumes a 125 MHz `clk`.
- `clk` in 1: 125 MHz transmit logic clock; all outputs registered on its rising edge.
- `rst` in 1: reset; synchronous, active-high. One clock; reset is synchronous and active-high.
- `speed` in 2: 2'b10 = 1000, 2'b01 = 100, 2'b00 = 10, 2'b11 treated as 1000. Sampled only at byte acceptance and during reset.
- `in_data` in 8: transmit byte.
- `in_en` in 1: GMII TX_EN for `in_data`.
- `in_er` in 1: GMII TX_ER for `in_data`.
- `in_ready` out 1: byte-accept strobe; byte/en/er captured on any rising edge where `in_ready`=1.
- `out_d_q1` out 4: data for rising edge of forwarded clock.
- `out_d_q2` out 4: data for falling edge.
- `out_ctl_q1` out 1: rising-edge control (TX_EN).
- `out_ctl_q2` out 1: falling-edge control (TX_EN xor TX_ER).
- `out_clk_q1` out 1: forwarded-clock value for first half of `clk` cycle.
- `out_clk_q2` out 1: forwarded-clock value for second half.

## Operation
- State: byte counter `cnt` (7 bits), latched speed `spd_r`, held high nibble and en/er of the accepted byte.
- Byte period P: 1 (1000), 10 (100), 100 (10). Half period H = P/2 (5 or 50; unused at 1000).
- `in_ready` = (`cnt` == P-1) and not `rst`, where P is derived from `spd_r`. At 1000 this is constantly 1 outside reset.
- Acceptance edge (`in_ready`=1):
  - Capture `in_data`, `in_en`, `in_er`; latch `spd_r` <= `speed`; set `cnt` <= 0.
  - 1000: `out_d_q1`=data[3:0], `out_d_q2`=data[7:4].
  - 10/100: `out_d_q1`=`out_d_q2`=data[3:0].
  - `out_ctl_q1`=en, `out_ctl_q2`=en^er.
- Other edges: `cnt` <= `cnt`+1. At the edge where `cnt` goes H-1 to H, load `out_d_q1`=`out_d_q2`=data[7:4]. Ctl outputs are unchanged (same en/er for both nibbles).
- Forwarded clock, as a function of `cnt` in the displayed cycle:
  - Outputs are registered from the next-state `cnt`, so clock, data and ctl always align.
  - h = `cnt` mod H.
  - 1000: (q1,q2) = (1,0) every cycle.
  - 100: h=0,1 gives (1,1); h=2 gives (1,0); h=3,4 gives (0,0). This is a 25 MHz, 50% clock.
  - 10: h<25 gives (1,1); h>=25 gives (0,0). This is 2.5 MHz.
- Every nibble starts on a forwarded-clock rising edge.
- The stream runs continuously. Idle bytes (en=er=0) are formatted identically; the block never stalls or inserts gaps.
- Speed change takes effect only at the next acceptance edge; the byte in flight completes at the old speed.
- Reset (any cycle, mid-byte included):
  - `cnt` <= P-1 using the new `spd_r`, so acceptance is possible on the first edge after release.
  - `spd_r` <= `speed`.
  - All data, ctl and clock outputs <= 0; `in_ready`=0 while `rst`=1.
  - Any partially sent byte is dropped.

## Timing
- Latency: a byte accepted at edge T appears on outputs in the cycle after T. At 10/100 the high nibble appears H cycles later.
- Throughput: 1 byte/cycle (1000), 1/10 (100), 1/100 (10).
- `in_ready` is high for exactly 1 cycle per byte period at 10/100. The first assertion is in the first cycle after `rst` deasserts.
- Upstream must present valid data whenever `in_ready`=1; no backpressure in the other direction.
- Reset values: all outputs 0.

## Test plan
- 1000 mode, bytes 0x5A,0xC3 with en=1, er=0 back to back:
  - `in_ready` constantly 1.
  - Outputs (q1,q2) = (A,5), then (3,C), one cycle after each byte.
  - ctl=(1,1); clk=(1,0) every cycle.
- 100 mode, byte 0x7E with en=1, er=1:
  - `in_ready` pulses every 10 cycles.
  - Outputs show E for 5 cycles, then 7 for 5 cycles; ctl=(1,0).
  - clk pattern 11,11,10,00,00 per nibble.
- 10 mode, byte 0x21:
  - Nibble 1 held 50 cycles, nibble 2 held 50 cycles.
  - clk high for 25 cycles, low for 25 cycles, per nibble.
  - `in_ready` period 100.
- Speed change 100 to 1000 asserted mid-byte: current byte completes its 10 cycles; 1000 formatting starts at the next acceptance.
- Reset asserted at `cnt`=6 in 100 mode:
  - Next cycle all outputs 0 and `in_ready`=0.
  - After release, `in_ready`=1 in the first cycle; the new byte is output from the cycle after.
- 2'b11 speed behaves identically to 2'b10.
